// File: rtl/runway_seq.sv
// runway_seq: prescaled runway light sequencer (calm / sweep-up / sweep-down / hold)
// Ports:
//   clk        clock, all state updates on its rising edge
//   reset      asynchronous active-low reset
//   SW[1:0]    mode select, sampled only on an internal tick:
//              00 calm, 01 sweep-up, 10 sweep-down, 11 hold
//   en         run enable; 0 clears the prescaler and freezes the pattern
//   rate       prescaler terminal count; a tick every rate+1 enabled cycles
//   LEDR       registered light pattern
//   tick       registered pulse, high in the cycle LEDR takes its new value
// Build option: define RUNWAY_SEQ_BLINK_EN to make HOLD blink the held pattern.
module runway_seq #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       SW,
  input  logic             en,
  input  logic [DIV_W-1:0] rate,
  output logic [WIDTH-1:0] LEDR,
  output logic             tick
);
  typedef enum logic [2:0] {IDLE, CALM, SWEEP_UP, SWEEP_DN, HOLD} state_t;
  function automatic logic [WIDTH-1:0] even_pat();
    logic [WIDTH-1:0] p;
    for (int i = 0; i < WIDTH; i++) p[i] = (i % 2 == 0);
    return p;
  endfunction
  localparam logic [WIDTH-1:0] EVEN = even_pat();
  localparam logic [WIDTH-1:0] MSB  = {1'b1, {(WIDTH-1){1'b0}}};
  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] led_q, led_d, held, src, rot_up, rot_dn;
  logic             tick_q, tick_d, itick, resume;
`ifdef RUNWAY_SEQ_BLINK_EN
  // While blinking, LEDR may read 0, so the pattern to resume from is kept aside.
  logic [WIDTH-1:0] hold_q, hold_d;
  assign held = hold_q;
`else
  assign held = led_q;
`endif
  // >= rather than == so a rate lowered below the count fires instead of wrapping.
  assign itick  = en && (cnt_q >= rate);
  assign src    = (state_q == HOLD) ? held : led_q;
  assign rot_up = {src[WIDTH-2:0], src[WIDTH-1]};
  assign rot_dn = {src[0], src[WIDTH-1:1]};
  // Sweeps keep their position when reversing, and resume from a one-hot held pattern.
  assign resume = (state_q == SWEEP_UP) || (state_q == SWEEP_DN) ||
                  ((state_q == HOLD) && $onehot(held));
  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    tick_d  = 1'b0;
    cnt_d   = itick || !en ? '0 : cnt_q + DIV_W'(1);
`ifdef RUNWAY_SEQ_BLINK_EN
    hold_d  = hold_q;
`endif
    if (state_q > HOLD) begin
      state_d = IDLE;
      led_d   = '0;
    end else if (itick) begin
      case (SW)
        2'b00: begin
          state_d = CALM;
          led_d   = (state_q == CALM) ? ~led_q : EVEN;
          tick_d  = 1'b1;
        end
        2'b01: begin
          state_d = SWEEP_UP;
          led_d   = resume ? rot_up : WIDTH'(1);
          tick_d  = 1'b1;
        end
        2'b10: begin
          state_d = SWEEP_DN;
          led_d   = resume ? rot_dn : MSB;
          tick_d  = 1'b1;
        end
        default: begin
          if (state_q != IDLE) begin
            state_d = HOLD;
`ifdef RUNWAY_SEQ_BLINK_EN
            if (state_q != HOLD) hold_d = led_q;
            else led_d = (led_q == '0) ? hold_q : '0;
            tick_d = 1'b1;
`endif
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      led_q   <= '0;
      tick_q  <= 1'b0;
`ifdef RUNWAY_SEQ_BLINK_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      tick_q  <= tick_d;
`ifdef RUNWAY_SEQ_BLINK_EN
      hold_q  <= hold_d;
`endif
    end
  end
  assign LEDR = led_q;
  assign tick = tick_q;
endmodule

// File: doc/runway_seq.md
RUNWAY_SEQ -- requirements
Module: runway_seq

Interface
REQ-001 Parameter WIDTH, default 8: number of runway lights; legal range 3..32.
REQ-002 Parameter DIV_W, default 16: width of the tick prescaler and of rate.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous reset, active-low; asserted while 0.
REQ-005 SW  input  2  mode select: 00 calm, 01 sweep-up, 10 sweep-down, 11 hold.
REQ-006 en  input  1  run enable; 0 freezes the sequence.
REQ-007 rate  input  DIV_W  prescaler terminal count; a tick fires every rate+1 enabled cycles.
REQ-008 LEDR  output  WIDTH  registered light pattern.
REQ-009 tick  output  1  registered one-cycle pulse, high in the cycle LEDR takes its new value.

Function
REQ-010 The block SHALL implement states IDLE, CALM, SWEEP_UP, SWEEP_DN, HOLD.
REQ-011 The prescaler SHALL count up while en=1 and assert an internal tick when count >= rate, then clear to 0 on the next cycle.
REQ-012 rate=0 SHALL produce a tick on every enabled cycle.
REQ-013 Lowering rate below the current count SHALL fire a tick on the next enabled cycle, never a counter wrap.
REQ-014 en=0 SHALL clear the prescaler, hold state and LEDR, and keep tick at 0.
REQ-015 SW SHALL be sampled only on an internal tick; changes between ticks have no effect.
REQ-016 LEDR and tick SHALL update one cycle after the internal tick.
REQ-017 CALM: entered from any other state, LEDR loads EVEN (bits 0,2,4.. set); in CALM each tick toggles LEDR between EVEN and ~EVEN.
REQ-018 SWEEP_UP: entered from any other state, LEDR loads bit 0 only; in SWEEP_UP each tick rotates LEDR one place toward the MSB, bit WIDTH-1 wrapping to bit 0.
REQ-019 SWEEP_DN: entered from any other state, LEDR loads bit WIDTH-1 only; in SWEEP_DN each tick rotates one place toward the LSB, bit 0 wrapping to bit WIDTH-1.
REQ-020 Direct SWEEP_UP<->SWEEP_DN switches SHALL keep the current one-hot position and reverse direction on that tick.
REQ-021 SW=11 SHALL move to HOLD with LEDR unchanged; from IDLE SW=11 SHALL leave the block in IDLE with LEDR=0.
REQ-022 Leaving HOLD SHALL apply the entry rules of REQ-017..REQ-019, except HOLD-to-sweep SHALL continue from the held one-hot if LEDR is one-hot.
REQ-023 LEDR SHALL never take an X or undefined value in any state, including for SW=11.
REQ-024 The state register SHALL decode illegal encodings to IDLE on the next clock.

Reset
REQ-025 reset=0 SHALL immediately force state IDLE, LEDR=0, tick=0, prescaler=0, independent of clk.
REQ-026 Reset deasserted mid-sequence SHALL restart from IDLE; the first tick occurs rate+1 enabled cycles after release.

Configuration
REQ-027 Macro RUNWAY_SEQ_BLINK_EN: when defined, HOLD SHALL toggle LEDR between the held pattern and 0 on each tick, and exit from HOLD SHALL use the held (non-zero) pattern.
REQ-028 Without RUNWAY_SEQ_BLINK_EN, HOLD SHALL keep LEDR static and emit no tick pulse.

Verification (WIDTH=8)
REQ-029 Reset=0 mid-sweep at LEDR=00010000 -> LEDR=00000000, tick=0 same cycle, no clock edge required.
REQ-030 en=1, rate=0, SW=01 from IDLE -> LEDR 01,02,04..80,01 on successive cycles, tick high every cycle.
REQ-031 en=1, rate=3, SW=00 -> LEDR 55, AA, 55 every 4 cycles; tick single-cycle pulses 4 apart.
REQ-032 SW=01 at LEDR=08, switch to SW=10 before next tick -> LEDR 04 then 02; SW glitch of 1 cycle between ticks -> ignored.
REQ-033 SW=11 at LEDR=20 -> LEDR stays 20 (no macro) or 20,00,20 per tick (macro); SW=10 afterward -> 10.
REQ-034 rate=100 with count at 50, rate changed to 10, en dropped for 5 cycles -> no tick while en=0, tick 11 enabled cycles after en returns.
